// File: rtl/aurora_link_supervisor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aurora_sup_pkg
// Description : State encoding, fixed widths and sizing helpers shared by the
//               Aurora link supervisor files.
// Revision    : 1.0 - initial release
// ============================================================================
package aurora_sup_pkg;

    localparam int c_STATE_W     = 2;
    localparam int c_RETRY_W     = 8;
    localparam int c_SYNC_STAGES = 2;

    localparam logic [c_STATE_W-1:0] ST_OFF  = 2'd0;
    localparam logic [c_STATE_W-1:0] ST_INIT = 2'd1;
    localparam logic [c_STATE_W-1:0] ST_WAIT = 2'd2;
    localparam logic [c_STATE_W-1:0] ST_UP   = 2'd3;

    typedef enum logic [c_STATE_W-1:0] {
        CH_OFF  = ST_OFF,
        CH_INIT = ST_INIT,
        CH_WAIT = ST_WAIT,
        CH_UP   = ST_UP
    } ch_state_e;

    // Bits needed to hold max_val itself (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aurora_link_supervisor_if.sv
`default_nettype none
// ============================================================================
// Module      : aurora_link_supervisor_if
// Description : Per-channel control, status and statistics bundle between the
//               supervisor and the Aurora wrapper / register block.
// Revision    : 1.0 - initial release
// ============================================================================
interface aurora_link_supervisor_if #(
    parameter int CH_NUM = 2,
    parameter int CNT_W  = 16
);
    import aurora_sup_pkg::*;

    logic [CH_NUM-1:0]             i_en;
    logic [CH_NUM-1:0]             i_channel_up;
    logic [CH_NUM-1:0]             i_hard_err;
    logic [CH_NUM-1:0]             i_soft_err;
    logic                          i_clr_cnt;
    logic [CH_NUM-1:0]             o_pma_init;
    logic [CH_NUM-1:0]             o_reset_pb;
    logic [CH_NUM-1:0]             o_link_ok;
    logic [c_STATE_W*CH_NUM-1:0]   o_state;
    logic [c_RETRY_W*CH_NUM-1:0]   o_retry_cnt;
    logic [CNT_W*CH_NUM-1:0]       o_hard_err_cnt;
    logic [CNT_W*CH_NUM-1:0]       o_soft_err_cnt;

    // The supervisor side.
    modport master (
        input  i_en, i_channel_up, i_hard_err, i_soft_err, i_clr_cnt,
        output o_pma_init, o_reset_pb, o_link_ok, o_state,
               o_retry_cnt, o_hard_err_cnt, o_soft_err_cnt
    );

    modport slave (
        output i_en, i_channel_up, i_hard_err, i_soft_err, i_clr_cnt,
        input  o_pma_init, o_reset_pb, o_link_ok, o_state,
               o_retry_cnt, o_hard_err_cnt, o_soft_err_cnt
    );

endinterface
`default_nettype wire

// File: rtl/aurora_link_supervisor_ch.sv
`default_nettype none
// ============================================================================
// Module      : aurora_ch_supervisor
// Description : One Aurora channel: input synchronisers, bring-up FSM,
//               soft-error window and saturating statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module aurora_ch_supervisor
    import aurora_sup_pkg::*;
#(
    parameter int INIT_CYC     = 1000,
    parameter int RST_TAIL     = 64,
    parameter int UP_TIMEOUT   = 10_000_000,
    parameter int WIN_CYC      = 100_000,
    parameter int SOFT_ERR_LIM = 16,
    parameter int CNT_W        = 16
) (
    input  wire                    i_clk_100M,
    input  wire                    i_rst,
    input  wire                    i_en,
    input  wire                    i_channel_up,
    input  wire                    i_hard_err,
    input  wire                    i_soft_err,
    input  wire                    i_clr_cnt,
    output logic                   o_pma_init,
    output logic                   o_reset_pb,
    output logic                   o_link_ok,
    output logic [c_STATE_W-1:0]   o_state,
    output logic [c_RETRY_W-1:0]   o_retry_cnt,
    output logic [CNT_W-1:0]       o_hard_err_cnt,
    output logic [CNT_W-1:0]       o_soft_err_cnt
);

    localparam int c_TMR_W  = cnt_width(max_int(INIT_CYC + RST_TAIL, UP_TIMEOUT));
    localparam int c_WTMR_W = cnt_width(WIN_CYC - 1);
    localparam int c_WCNT_W = cnt_width(SOFT_ERR_LIM);

    localparam logic [c_TMR_W-1:0]  c_PMA_END  = c_TMR_W'(INIT_CYC);
    localparam logic [c_TMR_W-1:0]  c_RST_END  = c_TMR_W'(INIT_CYC + RST_TAIL);
    localparam logic [c_TMR_W-1:0]  c_INIT_END = c_TMR_W'(INIT_CYC + RST_TAIL - 1);
    localparam logic [c_TMR_W-1:0]  c_UP_END   = c_TMR_W'(UP_TIMEOUT - 1);
    localparam logic [c_WTMR_W-1:0] c_WIN_END  = c_WTMR_W'(WIN_CYC - 1);
    localparam logic [c_WCNT_W-1:0] c_SOFT_LIM = c_WCNT_W'(SOFT_ERR_LIM);

    logic [c_SYNC_STAGES-1:0] r_up_sync;
    logic [c_SYNC_STAGES-1:0] r_hard_sync;
    logic [c_SYNC_STAGES-1:0] r_soft_sync;
    logic                     r_hard_d;
    logic                     r_soft_d;

    ch_state_e                r_state;
    ch_state_e                w_state_nxt;
    logic [c_TMR_W-1:0]       r_timer;
    logic [c_TMR_W-1:0]       w_timer_nxt;
    logic                     w_retry_evt;
    logic                     r_pma_init;
    logic                     r_reset_pb;
    logic                     r_link_ok;
    logic                     w_pma_init_nxt;
    logic                     w_reset_pb_nxt;
    logic                     w_link_ok_nxt;

    logic [c_WTMR_W-1:0]      r_win_tmr;
    logic [c_WCNT_W-1:0]      r_win_cnt;
    logic [c_WCNT_W-1:0]      w_win_cnt_nxt;
    logic                     w_win_end;
    logic                     w_soft_trip;

    logic [c_RETRY_W-1:0]     r_retry_cnt;
    logic [CNT_W-1:0]         r_hard_cnt;
    logic [CNT_W-1:0]         r_soft_cnt;

    logic w_up_s;
    logic w_hard_rise;
    logic w_soft_rise;

    assign w_up_s      = r_up_sync[c_SYNC_STAGES-1];
    assign w_hard_rise = r_hard_sync[c_SYNC_STAGES-1] & ~r_hard_d;
    assign w_soft_rise = r_soft_sync[c_SYNC_STAGES-1] & ~r_soft_d;

    always_ff @(posedge i_clk_100M) begin
        if (i_rst) begin
            r_up_sync   <= '0;
            r_hard_sync <= '0;
            r_soft_sync <= '0;
            r_hard_d    <= 1'b0;
            r_soft_d    <= 1'b0;
        end else begin
            r_up_sync   <= {r_up_sync[c_SYNC_STAGES-2:0], i_channel_up};
            r_hard_sync <= {r_hard_sync[c_SYNC_STAGES-2:0], i_hard_err};
            r_soft_sync <= {r_soft_sync[c_SYNC_STAGES-2:0], i_soft_err};
            r_hard_d    <= r_hard_sync[c_SYNC_STAGES-1];
            r_soft_d    <= r_soft_sync[c_SYNC_STAGES-1];
        end
    end

    // An edge landing on the last window cycle opens the next window at 1.
    always_comb begin
        w_win_end = (r_win_tmr == c_WIN_END);
        if (w_win_end) begin
            w_win_cnt_nxt = c_WCNT_W'(w_soft_rise);
        end else begin
            w_win_cnt_nxt = r_win_cnt + c_WCNT_W'(w_soft_rise);
        end
        w_soft_trip = (r_state == CH_UP) && (w_win_cnt_nxt >= c_SOFT_LIM);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer + 1'b1;
        w_retry_evt = 1'b0;
        case (r_state)
            CH_OFF: begin
                w_timer_nxt = '0;
                if (i_en) begin
                    w_state_nxt = CH_INIT;
                end
            end
            CH_INIT: begin
                if (r_timer == c_INIT_END) begin
                    w_state_nxt = CH_WAIT;
                    w_timer_nxt = '0;
                end
            end
            CH_WAIT: begin
                if (w_up_s) begin
                    w_state_nxt = CH_UP;
                    w_timer_nxt = '0;
                end else if (r_timer == c_UP_END) begin
                    w_state_nxt = CH_INIT;
                    w_timer_nxt = '0;
                    w_retry_evt = 1'b1;
                end
            end
            CH_UP: begin
                w_timer_nxt = '0;
                if (!w_up_s || w_hard_rise || w_soft_trip) begin
                    w_state_nxt = CH_INIT;
                    w_retry_evt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = CH_OFF;
                w_timer_nxt = '0;
            end
        endcase

        // Disable overrides every transition and is not a retry.
        if (!i_en) begin
            w_state_nxt = CH_OFF;
            w_timer_nxt = '0;
            w_retry_evt = 1'b0;
        end

        w_pma_init_nxt = (w_state_nxt == CH_OFF) ||
                         ((w_state_nxt == CH_INIT) && (w_timer_nxt < c_PMA_END));
        w_reset_pb_nxt = (w_state_nxt == CH_OFF) ||
                         ((w_state_nxt == CH_INIT) && (w_timer_nxt < c_RST_END));
        w_link_ok_nxt  = (w_state_nxt == CH_UP);
    end

    always_ff @(posedge i_clk_100M) begin
        if (i_rst) begin
            r_state    <= CH_OFF;
            r_timer    <= '0;
            r_pma_init <= 1'b1;
            r_reset_pb <= 1'b1;
            r_link_ok  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_pma_init <= w_pma_init_nxt;
            r_reset_pb <= w_reset_pb_nxt;
            r_link_ok  <= w_link_ok_nxt;
        end
    end

    always_ff @(posedge i_clk_100M) begin
        if (i_rst || (r_state != CH_UP) || (w_state_nxt != CH_UP)) begin
            r_win_tmr <= '0;
            r_win_cnt <= '0;
        end else begin
            r_win_tmr <= w_win_end ? '0 : r_win_tmr + 1'b1;
            r_win_cnt <= w_win_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk_100M) begin
        if (i_rst || i_clr_cnt) begin
            r_retry_cnt <= '0;
            r_hard_cnt  <= '0;
            r_soft_cnt  <= '0;
        end else begin
            if (w_retry_evt && (r_retry_cnt != '1)) begin
                r_retry_cnt <= r_retry_cnt + 1'b1;
            end
            if ((r_state != CH_OFF) && w_hard_rise && (r_hard_cnt != '1)) begin
                r_hard_cnt <= r_hard_cnt + 1'b1;
            end
            if ((r_state != CH_OFF) && w_soft_rise && (r_soft_cnt != '1)) begin
                r_soft_cnt <= r_soft_cnt + 1'b1;
            end
        end
    end

    assign o_pma_init     = r_pma_init;
    assign o_reset_pb     = r_reset_pb;
    assign o_link_ok      = r_link_ok;
    assign o_state        = r_state;
    assign o_retry_cnt    = r_retry_cnt;
    assign o_hard_err_cnt = r_hard_cnt;
    assign o_soft_err_cnt = r_soft_cnt;

endmodule
`default_nettype wire

// File: rtl/aurora_link_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : aurora_link_supervisor
// Description : Bring-up and recovery supervisor for CH_NUM independent
//               Aurora 8b10b channels sharing one GT quad.
// Revision    : 1.0 - initial release
// ============================================================================
module aurora_link_supervisor
    import aurora_sup_pkg::*;
#(
    parameter int CH_NUM       = 2,
    parameter int INIT_CYC     = 1000,
    parameter int RST_TAIL     = 64,
    parameter int UP_TIMEOUT   = 10_000_000,
    parameter int WIN_CYC      = 100_000,
    parameter int SOFT_ERR_LIM = 16,
    parameter int CNT_W        = 16
) (
    input  wire                       i_clk_100M,
    input  wire                       i_rst,
    aurora_link_supervisor_if.master  sup_if
);

    logic [CH_NUM-1:0][c_STATE_W-1:0] w_state;
    logic [CH_NUM-1:0][c_RETRY_W-1:0] w_retry_cnt;
    logic [CH_NUM-1:0][CNT_W-1:0]     w_hard_cnt;
    logic [CH_NUM-1:0][CNT_W-1:0]     w_soft_cnt;
    logic [CH_NUM-1:0]                w_pma_init;
    logic [CH_NUM-1:0]                w_reset_pb;
    logic [CH_NUM-1:0]                w_link_ok;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        aurora_ch_supervisor #(
            .INIT_CYC     (INIT_CYC),
            .RST_TAIL     (RST_TAIL),
            .UP_TIMEOUT   (UP_TIMEOUT),
            .WIN_CYC      (WIN_CYC),
            .SOFT_ERR_LIM (SOFT_ERR_LIM),
            .CNT_W        (CNT_W)
        ) u_ch (
            .i_clk_100M     (i_clk_100M),
            .i_rst          (i_rst),
            .i_en           (sup_if.i_en[k]),
            .i_channel_up   (sup_if.i_channel_up[k]),
            .i_hard_err     (sup_if.i_hard_err[k]),
            .i_soft_err     (sup_if.i_soft_err[k]),
            .i_clr_cnt      (sup_if.i_clr_cnt),
            .o_pma_init     (w_pma_init[k]),
            .o_reset_pb     (w_reset_pb[k]),
            .o_link_ok      (w_link_ok[k]),
            .o_state        (w_state[k]),
            .o_retry_cnt    (w_retry_cnt[k]),
            .o_hard_err_cnt (w_hard_cnt[k]),
            .o_soft_err_cnt (w_soft_cnt[k])
        );
    end

    // Channel k occupies slice k of every packed status vector.
    assign sup_if.o_pma_init     = w_pma_init;
    assign sup_if.o_reset_pb     = w_reset_pb;
    assign sup_if.o_link_ok      = w_link_ok;
    assign sup_if.o_state        = w_state;
    assign sup_if.o_retry_cnt    = w_retry_cnt;
    assign sup_if.o_hard_err_cnt = w_hard_cnt;
    assign sup_if.o_soft_err_cnt = w_soft_cnt;

endmodule
`default_nettype wire

// File: tb/tb_aurora_link_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_aurora_link_supervisor
// Description : Directed self-checking bench for aurora_link_supervisor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aurora_link_supervisor;

    localparam int CH_NUM       = 2;
    localparam int INIT_CYC     = 8;
    localparam int RST_TAIL     = 4;
    localparam int UP_TIMEOUT   = 50;
    localparam int WIN_CYC      = 20;
    localparam int SOFT_ERR_LIM = 3;
    localparam int CNT_W        = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   cyc       = 0;

    aurora_link_supervisor_if #(.CH_NUM(CH_NUM), .CNT_W(CNT_W)) sup_if ();

    aurora_link_supervisor #(
        .CH_NUM       (CH_NUM),
        .INIT_CYC     (INIT_CYC),
        .RST_TAIL     (RST_TAIL),
        .UP_TIMEOUT   (UP_TIMEOUT),
        .WIN_CYC      (WIN_CYC),
        .SOFT_ERR_LIM (SOFT_ERR_LIM),
        .CNT_W        (CNT_W)
    ) dut (
        .i_clk_100M (clk),
        .i_rst      (rst),
        .sup_if     (sup_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // cyc = number of rising edges since reset release; position is 1 ns after that edge.
    task automatic go_to(input int p);
        while (cyc < p) tick();
    endtask

    initial begin
        rst                 = 1'b1;
        sup_if.i_en         = 2'b11;
        sup_if.i_channel_up = 2'b00;
        sup_if.i_hard_err   = 2'b00;
        sup_if.i_soft_err   = 2'b00;
        sup_if.i_clr_cnt    = 1'b0;
        repeat (3) tick();
        check("rst_state",   64'(sup_if.o_state),        64'(0));
        check("rst_pma",     64'(sup_if.o_pma_init),     64'(3));
        check("rst_rstpb",   64'(sup_if.o_reset_pb),     64'(3));
        check("rst_link",    64'(sup_if.o_link_ok),      64'(0));
        check("rst_retry",   64'(sup_if.o_retry_cnt),    64'(0));
        check("rst_hardcnt", 64'(sup_if.o_hard_err_cnt), 64'(0));
        check("rst_softcnt", 64'(sup_if.o_soft_err_cnt), 64'(0));
        rst = 1'b0;
        cyc = 0;

        // Bring-up: INIT 12 cycles (pma_init 8, reset_pb 12), then WAIT.
        go_to(1);
        check("init_state",  64'(sup_if.o_state),    64'(4'b0101));
        check("init_pma",    64'(sup_if.o_pma_init), 64'(3));
        go_to(8);
        check("pma_last",    64'(sup_if.o_pma_init), 64'(3));
        go_to(9);
        check("pma_rel",     64'(sup_if.o_pma_init), 64'(0));
        check("rstpb_tail0", 64'(sup_if.o_reset_pb), 64'(3));
        go_to(12);
        check("rstpb_tail3", 64'(sup_if.o_reset_pb), 64'(3));
        check("init_last",   64'(sup_if.o_state),    64'(4'b0101));
        go_to(13);
        check("wait_state",  64'(sup_if.o_state),    64'(4'b1010));
        check("rstpb_rel",   64'(sup_if.o_reset_pb), 64'(0));

        // ch0 channel_up: three-cycle latency to UP.
        sup_if.i_channel_up = 2'b01;
        go_to(15);
        check("up_lat2_st",  64'(sup_if.o_state[1:0]), 64'(2));
        check("up_lat2_ok",  64'(sup_if.o_link_ok),    64'(0));
        go_to(16);
        check("up_state",    64'(sup_if.o_state[1:0]), 64'(3));
        check("up_link",     64'(sup_if.o_link_ok),    64'(1));

        // ch1 WAIT timeout after 50 cycles.
        go_to(62);
        check("ch1_wait",    64'(sup_if.o_state[3:2]),     64'(2));
        check("ch1_retry0",  64'(sup_if.o_retry_cnt[15:8]), 64'(0));
        go_to(63);
        check("ch1_tmo_st",  64'(sup_if.o_state[3:2]),     64'(1));
        check("ch1_retry1",  64'(sup_if.o_retry_cnt[15:8]), 64'(1));
        check("ch0_still",   64'(sup_if.o_state[1:0]),     64'(3));
        check("ch0_retry0",  64'(sup_if.o_retry_cnt[7:0]), 64'(0));
        sup_if.i_en = 2'b01;
        go_to(64);
        check("ch1_off",     64'(sup_if.o_state[3:2]),     64'(0));
        check("ch1_off_pma", 64'(sup_if.o_pma_init[1]),    64'(1));
        check("ch1_off_rpb", 64'(sup_if.o_reset_pb[1]),    64'(1));
        check("ch1_keep",    64'(sup_if.o_retry_cnt[15:8]), 64'(1));

        // Three soft edges inside one window (edges counted at 80, 84, 88).
        for (int i = 0; i < 3; i++) begin
            go_to(77 + 4 * i);
            sup_if.i_soft_err = 2'b01;
            go_to(79 + 4 * i);
            sup_if.i_soft_err = 2'b00;
        end
        go_to(87);
        check("soft2_up",    64'(sup_if.o_state[1:0]),        64'(3));
        check("soft2_cnt",   64'(sup_if.o_soft_err_cnt[15:0]), 64'(2));
        go_to(88);
        check("soft_trip",   64'(sup_if.o_state[1:0]),        64'(1));
        check("soft_retry",  64'(sup_if.o_retry_cnt[7:0]),    64'(1));
        check("soft3_cnt",   64'(sup_if.o_soft_err_cnt[15:0]), 64'(3));
        check("soft_linkdn", 64'(sup_if.o_link_ok),           64'(0));

        // UP again at 101; windows close before edges 121, 141.
        // Edges at 113, 117 then 121 (boundary, opens new window at 1).
        for (int i = 0; i < 3; i++) begin
            go_to(110 + 4 * i);
            sup_if.i_soft_err = 2'b01;
            go_to(112 + 4 * i);
            sup_if.i_soft_err = 2'b00;
        end
        go_to(122);
        check("split_up",    64'(sup_if.o_state[1:0]),        64'(3));
        check("split_cnt",   64'(sup_if.o_soft_err_cnt[15:0]), 64'(6));
        check("split_retry", 64'(sup_if.o_retry_cnt[7:0]),    64'(1));
        for (int i = 0; i < 2; i++) begin
            go_to(122 + 4 * i);
            sup_if.i_soft_err = 2'b01;
            go_to(124 + 4 * i);
            sup_if.i_soft_err = 2'b00;
        end
        go_to(128);
        check("bnd_up",      64'(sup_if.o_state[1:0]),        64'(3));
        go_to(129);
        check("bnd_trip",    64'(sup_if.o_state[1:0]),        64'(1));
        check("bnd_retry",   64'(sup_if.o_retry_cnt[7:0]),    64'(2));
        check("bnd_cnt",     64'(sup_if.o_soft_err_cnt[15:0]), 64'(8));

        // UP at 142; hard_err and channel_up drop together -> one retry.
        go_to(150);
        sup_if.i_hard_err   = 2'b01;
        sup_if.i_channel_up = 2'b00;
        go_to(152);
        sup_if.i_hard_err   = 2'b00;
        check("dual_pre_st", 64'(sup_if.o_state[1:0]),     64'(3));
        check("dual_pre_rt", 64'(sup_if.o_retry_cnt[7:0]), 64'(2));
        go_to(153);
        check("dual_state",  64'(sup_if.o_state[1:0]),        64'(1));
        check("dual_retry",  64'(sup_if.o_retry_cnt[7:0]),    64'(3));
        check("dual_hard",   64'(sup_if.o_hard_err_cnt[15:0]), 64'(1));
        check("dual_link",   64'(sup_if.o_link_ok),           64'(0));

        // Disable ch0 mid-INIT (timer 9), then re-enable.
        go_to(162);
        check("mid_init",    64'(sup_if.o_state[1:0]),  64'(1));
        check("mid_pma",     64'(sup_if.o_pma_init[0]), 64'(0));
        check("mid_rstpb",   64'(sup_if.o_reset_pb[0]), 64'(1));
        sup_if.i_en = 2'b00;
        go_to(163);
        check("dis_state",   64'(sup_if.o_state[1:0]),     64'(0));
        check("dis_pma",     64'(sup_if.o_pma_init[0]),    64'(1));
        check("dis_rstpb",   64'(sup_if.o_reset_pb[0]),    64'(1));
        check("dis_retry",   64'(sup_if.o_retry_cnt[7:0]), 64'(3));
        go_to(165);
        sup_if.i_en = 2'b01;
        go_to(166);
        check("reen_state",  64'(sup_if.o_state[1:0]), 64'(1));

        // Clear coincides with a hard edge counted at 170.
        go_to(167);
        sup_if.i_hard_err = 2'b01;
        go_to(169);
        sup_if.i_hard_err = 2'b00;
        check("preclr_hard", 64'(sup_if.o_hard_err_cnt[15:0]), 64'(1));
        check("preclr_rt",   64'(sup_if.o_retry_cnt[7:0]),     64'(3));
        sup_if.i_clr_cnt = 1'b1;
        go_to(170);
        sup_if.i_clr_cnt = 1'b0;
        check("clr_retry",   64'(sup_if.o_retry_cnt),    64'(0));
        check("clr_hard",    64'(sup_if.o_hard_err_cnt), 64'(0));
        check("clr_soft",    64'(sup_if.o_soft_err_cnt), 64'(0));
        check("clr_fsm",     64'(sup_if.o_state[1:0]),   64'(1));
        go_to(173);
        check("reen_pma7",   64'(sup_if.o_pma_init[0]), 64'(1));
        go_to(174);
        check("reen_pma8",   64'(sup_if.o_pma_init[0]), 64'(0));

        go_to(175);
        sup_if.i_hard_err = 2'b01;
        go_to(177);
        sup_if.i_hard_err = 2'b00;
        go_to(178);
        check("post_clr_hd", 64'(sup_if.o_hard_err_cnt[15:0]), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
